// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory access responder.
// State encoding, wait-state limits and word-alignment helper.
package mem_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } mem_resp_state_t;

    localparam int MEM_WAIT_MAX   = 15;
    localparam int MEM_WORD_BYTES = 4;
    localparam int MEM_CNT_W      = 4;
    localparam int MEM_OFS_W      = $clog2(MEM_WORD_BYTES);

    function automatic logic word_misaligned(input logic [MEM_OFS_W-1:0] lsbs);
        return (lsbs != '0);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter for responder wait states; saturates at zero.
// zero_o/last_o decode the current count (0 and 1) combinationally.
module wait_counter
    import mem_resp_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [MEM_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o,
    output logic                 last_o
);

    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == MEM_CNT_W'(1));

endmodule

// File: rtl/mem_access_responder.sv
// Single-outstanding word RAM responder: one access per req, done after WAIT_CYCLES+2 cycles (1 for misaligned).
// ready is low while busy; req seen while busy is dropped, not queued.
module mem_access_responder
    import mem_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ready,
    output logic                 done,
    output logic [DATA_W-1:0]    rdata,
    output logic                 misalign_err,
    output logic [ADDR_W-3:0]    ram_addr,
    output logic                 ram_we,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MEM_WAIT_MAX) begin : g_wait_range
        $error("mem_access_responder: WAIT_CYCLES must be within 0..15");
    end

    localparam logic [MEM_CNT_W-1:0] WAIT_LOAD = MEM_CNT_W'(WAIT_CYCLES);

    mem_resp_state_t   state_q, state_d;
    logic              we_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-3:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic accept, misaligned, read_done;

    assign accept     = (state_q == ST_IDLE) && req;
    assign misaligned = word_misaligned(addr[MEM_OFS_W-1:0]);
    assign read_done  = (state_q == ST_DONE) && !we_q;

    wait_counter u_wait_counter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = misaligned ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_load = 1'b1;
                state_d  = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                // zero is a guard only; a loaded count always passes through 1
                if (cnt_last || cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= (state_d == ST_DONE) || (state_d == ST_ERR);
            err_q    <= (state_d == ST_ERR);
            ram_we_q <= 1'b0;
            if (accept && !misaligned) begin
                ram_addr_q  <= addr[ADDR_W-1:MEM_OFS_W];
                ram_wdata_q <= wdata;
                ram_we_q    <= we;
                we_q        <= we;
            end
            if (read_done) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // The RAM word only lands in the DONE cycle when WAIT_CYCLES=0, so it is
    // forwarded during DONE and held in rdata_q from the next cycle on.
    assign rdata        = read_done ? ram_rdata : rdata_q;
    assign ready        = (state_q == ST_IDLE);
    assign done         = done_q;
    assign misalign_err = err_q;
    assign ram_addr     = ram_addr_q;
    assign ram_we       = ram_we_q;
    assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Randomised scoreboard bench for mem_access_responder (WAIT_CYCLES=2) plus a
// directed pass over a WAIT_CYCLES=0 instance.
module tb_mem_access_responder;

    localparam int W = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;

    logic        req, we;
    logic [31:0] addr, wdata;
    logic        ready, done, misalign_err;
    logic [31:0] rdata;
    logic [29:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;

    mem_access_responder #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .misalign_err(misalign_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [31:0] ram [16];
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr[3:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[3:0]];
    end

    logic        z_req, z_we;
    logic [31:0] z_addr, z_wdata;
    logic        z_ready, z_done, z_err;
    logic [31:0] z_rdata;
    logic [29:0] z_ram_addr;
    logic        z_ram_we;
    logic [31:0] z_ram_wdata, z_ram_rdata;

    mem_access_responder #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clock(clock), .reset(reset), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
        .ready(z_ready), .done(z_done), .rdata(z_rdata), .misalign_err(z_err),
        .ram_addr(z_ram_addr), .ram_we(z_ram_we), .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata)
    );

    logic [31:0] z_ram [16];
    always @(posedge clock) begin
        if (z_ram_we) z_ram[z_ram_addr[3:0]] <= z_ram_wdata;
        z_ram_rdata <= z_ram[z_ram_addr[3:0]];
    end

    // Reference model: word memory image plus the last value a read returned.
    logic [31:0] ref_mem [16];
    logic [31:0] last_rd;
    logic [31:0] z_ref [16];
    logic [31:0] z_last;

    typedef struct { int acc; int due; logic [31:0] rd; logic err; } exp_t;
    typedef struct { int cyc; logic [29:0] a; logic w; logic [31:0] d; } ram_exp_t;
    exp_t     done_q[$];
    ram_exp_t ram_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic void model_issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t     e;
        ram_exp_t r;
        e.acc = cyc;
        e.err = (a[1:0] != 2'b00);
        if (e.err) begin
            e.due = cyc + 1;
            e.rd  = last_rd;
        end else begin
            e.due = cyc + W + 2;
            if (w) ref_mem[a[5:2]] = d;
            else   last_rd = ref_mem[a[5:2]];
            e.rd  = last_rd;
            r.cyc = cyc + 1;
            r.a   = a[31:2];
            r.w   = w;
            r.d   = d;
            ram_q.push_back(r);
        end
        done_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            exp_t     e;
            ram_exp_t r;
            chk("ready", ready, (done_q.size() == 0 || done_q[0].acc >= cyc) ? 1 : 0);
            if (done) begin
                if (done_q.size() == 0) begin
                    flag("done_unexpected");
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("rdata", rdata, e.rd);
                    chk("misalign_err", misalign_err, e.err);
                end
            end else begin
                chk("misalign_without_done", misalign_err, 0);
                if (done_q.size() > 0 && cyc >= done_q[0].due) begin
                    flag("done_missing");
                    void'(done_q.pop_front());
                end
            end
            if (ram_q.size() > 0 && ram_q[0].cyc == cyc) begin
                r = ram_q.pop_front();
                chk("ram_addr", ram_addr, r.a);
                chk("ram_we", ram_we, r.w);
                if (r.w) chk("ram_wdata", ram_wdata, r.d);
            end else begin
                chk("ram_we_idle", ram_we, 0);
            end
        end
    end

    // Called at posedge+#1; issues one request, driving noise while busy.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d, input bit noise);
        int budget = 0;
        while (!ready && budget < 40) begin
            req   = noise ? 1'b1 : 1'($urandom);
            we    = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            @(posedge clock); #1;
            budget++;
        end
        if (!ready) begin
            flag("ready_timeout");
            req = 1'b0;
            return;
        end
        req = 1'b1; we = w; addr = a; wdata = d;
        model_issue(w, a, d);
        @(posedge clock); #1;
        req = 1'b0;
    endtask

    task automatic z_op(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          acc;
        bit          seen = 0;
        bit          mis;
        logic [31:0] exp_rd;
        int          budget = 0;
        while (!z_ready && budget < 20) begin
            @(posedge clock); #1;
            budget++;
        end
        mis = (a[1:0] != 2'b00);
        if (!mis && w)       z_ref[a[5:2]] = d;
        else if (!mis && !w) z_last = z_ref[a[5:2]];
        exp_rd = z_last;
        acc = cyc;
        z_req = 1'b1; z_we = w; z_addr = a; z_wdata = d;
        @(posedge clock); #1;
        z_req = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (z_done) begin
                seen = 1;
                chk("w0_done_cycle", cyc, acc + (mis ? 1 : 2));
                chk("w0_rdata", z_rdata, exp_rd);
                chk("w0_misalign_err", z_err, {31'd0, mis});
            end
        end
        if (!seen) flag("w0_done_timeout");
        @(posedge clock); #1;
    endtask

    initial begin
        int gap;
        logic [31:0] a;
        req = 0; we = 0; addr = 0; wdata = 0;
        z_req = 0; z_we = 0; z_addr = 0; z_wdata = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom;   ref_mem[i] = ram[i];
            z_ram[i] = $urandom; z_ref[i] = z_ram[i];
        end
        ram[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
        last_rd = 0; z_last = 0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        reset = 1'b0;
        mon_en = 1;

        do_op(0, 32'h0C, 32'h0, 1);
        do_op(1, 32'h10, 32'h12345678, 1);
        do_op(0, 32'h10, 32'h0, 1);
        do_op(0, 32'h0E, 32'h0, 1);
        do_op(1, 32'h0D, 32'hFFFFFFFF, 1);
        do_op(0, 32'h0C, 32'h0, 0);

        // Abort an access with reset while it sits in a wait state.
        do_op(1, 32'h14, 32'hA5A5A5A5, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        done_q.delete();
        ram_q.delete();
        last_rd = 0;
        #1;
        chk("abort_ram_we", ram_we, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        // The aborted write may or may not have reached the RAM; resync the model.
        ref_mem[5] = ram[5];
        repeat (8) @(posedge clock);
        #1;
        do_op(0, 32'h14, 32'h0, 0);

        repeat (150) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                req = 0;
                @(posedge clock); #1;
            end
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_op(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        req = 0;
        for (int k = 0; k < 20 && (done_q.size() > 0 || ram_q.size() > 0); k++) begin
            @(posedge clock); #1;
        end
        if (done_q.size() > 0 || ram_q.size() > 0) flag("drain_timeout");
        mon_en = 0;

        z_op(0, 32'h00, 32'h0);
        z_op(0, 32'h08, 32'h0);
        z_op(1, 32'h08, 32'hCAFEF00D);
        z_op(0, 32'h08, 32'h0);
        z_op(0, 32'h05, 32'h0);
        z_op(0, 32'h3C, 32'h0);
        z_op(0, 32'h00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
